// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared widths, frame length and state type for the result serializer (MATRIX_SER_SUM_EN adds the sum word)
package matrix_pkg;

  localparam int DATA_W = 16;
  localparam int ELEM_W = 8;

`ifdef MATRIX_SER_SUM_EN
  localparam int NUM_WORDS = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SUM  = 2'd2
  } ser_state_t;
`else
  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
  } ser_state_t;
`endif

  // Index carried on out_idx by the final word of a frame.
  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

endpackage

// File: rtl/matrix_result_ser.sv
// rtl/matrix_result_ser.sv - serializes a captured 2x2 result matrix onto a valid/ready word stream (MATRIX_SER_SUM_EN appends the element sum)
module matrix_result_ser
  import matrix_pkg::*;
#(
  parameter int DATA_W = matrix_pkg::DATA_W,
  parameter int ELEM_W = matrix_pkg::ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] C11,
  input  logic [DATA_W-1:0] C12,
  input  logic [DATA_W-1:0] C21,
  input  logic [DATA_W-1:0] C22,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  // Result words may be narrower than a full element product; nothing to build for that case.
  if (DATA_W < 2 * ELEM_W) begin : g_narrow_result
  end

  ser_state_t        state, state_n;
  logic [2:0]        idx, idx_n, idx_inc;
  logic [DATA_W-1:0] c11_q, c12_q, c21_q, c22_q;
  logic [DATA_W-1:0] c11_n, c12_n, c21_n, c22_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              last_q, last_n;
  logic              ovr_q, ovr_n;
  logic              xfer;
  logic              do_cap;

`ifdef MATRIX_SER_SUM_EN
  logic [DATA_W-1:0] sum_w;

  // Sum of the held matrix, wrapping at DATA_W bits.
  always_comb begin
    sum_w = c11_q + c12_q + c21_q + c22_q;
  end
`endif

  // Registered stream state; outputs hold whenever nothing is transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= 3'd0;
      data_q <= '0;
      last_q <= 1'b0;
      ovr_q  <= 1'b0;
      c11_q  <= '0;
      c12_q  <= '0;
      c21_q  <= '0;
      c22_q  <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      data_q <= data_n;
      last_q <= last_n;
      ovr_q  <= ovr_n;
      c11_q  <= c11_n;
      c12_q  <= c12_n;
      c21_q  <= c21_n;
      c22_q  <= c22_n;
    end
  end

  // Next-state: capture when idle or on the final transfer, otherwise step one word per transfer.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data_q;
    last_n  = last_q;
    ovr_n   = ovr_q;
    c11_n   = c11_q;
    c12_n   = c12_q;
    c21_n   = c21_q;
    c22_n   = c22_q;
    do_cap  = 1'b0;
    idx_inc = idx + 3'd1;
    xfer    = (state != S_IDLE) && out_ready;

    case (state)
      S_IDLE: begin
        if (done) do_cap = 1'b1;
      end
      default: begin
        // A pulse is only usable when it lands on the final transfer; any other busy pulse is lost.
        if (done) begin
          if (xfer && (idx == LAST_IDX)) do_cap = 1'b1;
          else                           ovr_n  = 1'b1;
        end
        if (xfer) begin
          if (idx == LAST_IDX) begin
            if (!done) state_n = S_IDLE;
          end
`ifdef MATRIX_SER_SUM_EN
          else if (idx == 3'd3) begin
            state_n = S_SUM;
            idx_n   = 3'd4;
            data_n  = sum_w;
            last_n  = 1'b1;
          end
`endif
          else begin
            idx_n  = idx_inc;
            last_n = (idx_inc == LAST_IDX);
            case (idx_inc[1:0])
              2'd1:    data_n = c12_q;
              2'd2:    data_n = c21_q;
              2'd3:    data_n = c22_q;
              default: data_n = c11_q;
            endcase
          end
        end
      end
    endcase

    if (do_cap) begin
      state_n = S_SEND;
      idx_n   = 3'd0;
      data_n  = C11;
      last_n  = 1'b0;
      c11_n   = C11;
      c12_n   = C12;
      c21_n   = C21;
      c22_n   = C22;
    end
  end

  assign out_valid = (state != S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_data  = data_q;
  assign out_idx   = idx;
  assign out_last  = last_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_matrix_result_ser.sv
// tb/tb_matrix_result_ser.sv - table-driven bench for matrix_result_ser (MATRIX_SER_SUM_EN selects 5-word expectations)
module tb_matrix_result_ser;

`ifdef MATRIX_SER_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif
  localparam logic [2:0] LAST = SUM_EN ? 3'd4 : 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [15:0] c11, c12, c21, c22;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        overrun;

  matrix_result_ser dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .C11       (c11),
    .C12       (c12),
    .C21       (c21),
    .C22       (c22),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        done;
    logic [15:0] a, b, c, d;
    logic        rdy;
    logic        ev;
    logic        chk;
    logic [15:0] ed;
    logic [2:0]  ei;
    logic        el;
    logic        eb;
    logic        eo;
  } row_t;

  row_t rows[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cmp(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
    end
  endtask

  task automatic add(input logic rst_i, input logic done_i,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                     input logic rdy, input logic ev, input logic chk,
                     input logic [15:0] ed, input logic [2:0] ei, input logic el,
                     input logic eb, input logic eo);
    row_t r;
    r.rst = rst_i; r.done = done_i;
    r.a = a; r.b = b; r.c = c; r.d = d;
    r.rdy = rdy; r.ev = ev; r.chk = chk;
    r.ed = ed; r.ei = ei; r.el = el; r.eb = eb; r.eo = eo;
    rows.push_back(r);
  endtask

  // A valid word on the stream, no done, no reset.
  task automatic wd(input logic [15:0] d, input logic [2:0] i, input logic rdy, input logic eo);
    add(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, rdy, 1'b1, 1'b1, d, i, (i == LAST), 1'b1, eo);
  endtask

  // Idle cycle carrying a done pulse.
  task automatic idle_done(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d, input logic eo);
    add(1'b0, 1'b1, a, b, c, d, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0, eo);
  endtask

  // Idle cycle with out_ready high, which must be ignored.
  task automatic idle(input logic eo);
    add(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0, eo);
  endtask

  initial begin
    int timeout;
    logic seen_last;
    logic [15:0] last_word;

    rst = 1'b1; done = 1'b0; out_ready = 1'b0;
    c11 = '0; c12 = '0; c21 = '0; c22 = '0;

    // Basic frame, first done right after reset.
    add(1'b0, 1'b1, 16'd31, 16'd36, 16'd27, 16'd32, 1'b1, 1'b0, 1'b1, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    wd(16'd31, 3'd0, 1'b1, 1'b0);
    wd(16'd36, 3'd1, 1'b1, 1'b0);
    wd(16'd27, 3'd2, 1'b1, 1'b0);
    wd(16'd32, 3'd3, 1'b1, 1'b0);
    if (SUM_EN) wd(16'd126, 3'd4, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1,
        SUM_EN ? 16'd126 : 16'd32, LAST, 1'b1, 1'b0, 1'b0);

    // Stalls with ready 1,0,0,1.
    idle_done(16'd31, 16'd36, 16'd27, 16'd32, 1'b0);
    wd(16'd31, 3'd0, 1'b1, 1'b0);
    wd(16'd36, 3'd1, 1'b0, 1'b0);
    wd(16'd36, 3'd1, 1'b0, 1'b0);
    wd(16'd36, 3'd1, 1'b1, 1'b0);
    wd(16'd27, 3'd2, 1'b1, 1'b0);
    wd(16'd32, 3'd3, 1'b1, 1'b0);
    if (SUM_EN) wd(16'd126, 3'd4, 1'b1, 1'b0);
    idle(1'b0);

    // Second done at idx 1 is dropped and sets overrun.
    idle_done(16'd31, 16'd36, 16'd27, 16'd32, 1'b0);
    wd(16'd31, 3'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0, 1'b1, 1'b1, 16'd36, 3'd1, 1'b0, 1'b1, 1'b0);
    wd(16'd36, 3'd1, 1'b1, 1'b1);
    wd(16'd27, 3'd2, 1'b1, 1'b1);
    wd(16'd32, 3'd3, 1'b1, 1'b1);
    if (SUM_EN) wd(16'd126, 3'd4, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    add(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Capture in the first cycle after reset, then done on the final transfer.
    add(1'b0, 1'b1, 16'd31, 16'd36, 16'd27, 16'd32, 1'b0, 1'b0, 1'b1, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    wd(16'd31, 3'd0, 1'b1, 1'b0);
    wd(16'd36, 3'd1, 1'b1, 1'b0);
    wd(16'd27, 3'd2, 1'b1, 1'b0);
    if (SUM_EN) begin
      wd(16'd32, 3'd3, 1'b1, 1'b0);
      add(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b1, 1'b1, 16'd126, 3'd4, 1'b1, 1'b1, 1'b0);
    end else begin
      add(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b1, 1'b1, 16'd32, 3'd3, 1'b1, 1'b1, 1'b0);
    end
    wd(16'd1, 3'd0, 1'b1, 1'b0);
    wd(16'd2, 3'd1, 1'b1, 1'b0);
    wd(16'd3, 3'd2, 1'b1, 1'b0);
    wd(16'd4, 3'd3, 1'b1, 1'b0);
    if (SUM_EN) wd(16'd10, 3'd4, 1'b1, 1'b0);
    idle(1'b0);

    // Reset mid-frame at idx 2, then a fresh frame.
    idle_done(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
    wd(16'd5, 3'd0, 1'b1, 1'b0);
    wd(16'd6, 3'd1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 16'd7, 3'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'd9, 16'd10, 16'd11, 16'd12, 1'b1, 1'b0, 1'b1, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    wd(16'd9, 3'd0, 1'b1, 1'b0);
    wd(16'd10, 3'd1, 1'b1, 1'b0);
    wd(16'd11, 3'd2, 1'b1, 1'b0);
    wd(16'd12, 3'd3, 1'b1, 1'b0);
    if (SUM_EN) wd(16'd42, 3'd4, 1'b1, 1'b0);
    idle(1'b0);

    // Wrapping sum.
    idle_done(16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    wd(16'hFFFF, 3'd0, 1'b1, 1'b0);
    wd(16'h0001, 3'd1, 1'b1, 1'b0);
    wd(16'h0002, 3'd2, 1'b1, 1'b0);
    wd(16'h0003, 3'd3, 1'b1, 1'b0);
    if (SUM_EN) wd(16'h0005, 3'd4, 1'b1, 1'b0);
    idle(1'b0);

    // Reset state.
    repeat (2) @(negedge clk);
    cmp("reset_valid", -1, 32'(out_valid), 32'd0);
    cmp("reset_busy", -1, 32'(busy), 32'd0);
    cmp("reset_overrun", -1, 32'(overrun), 32'd0);
    cmp("reset_data", -1, 32'(out_data), 32'd0);
    cmp("reset_idx", -1, 32'(out_idx), 32'd0);
    cmp("reset_last", -1, 32'(out_last), 32'd0);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      rst = rows[i].rst; done = rows[i].done;
      c11 = rows[i].a; c12 = rows[i].b; c21 = rows[i].c; c22 = rows[i].d;
      out_ready = rows[i].rdy;
      cmp("valid", i, 32'(out_valid), 32'(rows[i].ev));
      cmp("busy", i, 32'(busy), 32'(rows[i].eb));
      cmp("overrun", i, 32'(overrun), 32'(rows[i].eo));
      if (rows[i].chk) begin
        cmp("data", i, 32'(out_data), 32'(rows[i].ed));
        cmp("idx", i, 32'(out_idx), 32'(rows[i].ei));
        cmp("last", i, 32'(out_last), 32'(rows[i].el));
      end
    end

    // Long stall on the first word, then drain with a bounded wait for the last word.
    @(negedge clk);
    rst = 1'b0; done = 1'b1; out_ready = 1'b0;
    c11 = 16'd100; c12 = 16'd200; c21 = 16'd300; c22 = 16'd400;
    @(negedge clk);
    done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cmp("stall_valid", k, 32'(out_valid), 32'd1);
      cmp("stall_data", k, 32'(out_data), 32'd100);
      cmp("stall_idx", k, 32'(out_idx), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    seen_last = 1'b0;
    last_word = '0;
    timeout = 0;
    while (!seen_last && timeout < 12) begin
      if (out_valid && out_last) begin
        seen_last = 1'b1;
        last_word = out_data;
      end
      @(negedge clk);
      timeout++;
    end
    cmp("drain_seen_last", 0, 32'(seen_last), 32'd1);
    cmp("drain_last_word", 0, 32'(last_word), SUM_EN ? 32'd1000 : 32'd400);
    cmp("drain_idle", 0, 32'(out_valid), 32'd0);
    cmp("drain_overrun", 0, 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
